swap_cmd_scheduler: RTL and testbench
=====================================

// Module: swap_cmd_scheduler
// PURPOSE
//  Upstream command stage for the memory swapper: queues swap requests (address pairs) from a
//  valid/ready source and sequences them onto the swapper's address_A/address_B/swap inputs.
//  Also arbitrates the swapper's single write port: host writes pass through except while a
//  swap is in flight, when they are stalled so a swap never races a write.
// PARAMETERS
//  ADDR_WIDTH   7  memory address width
//  DATA_WIDTH   8  memory data width
//  FIFO_DEPTH   4  swap request queue depth (power of 2, >=2)
//  SWAP_CYCLES  3  cycles swap is held high per request (>=1)
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high reset
//  req_valid      in   1           swap request offered
//  req_ready      out  1           request queue can accept (= !full)
//  req_addr_a     in   ADDR_WIDTH  first swap address
//  req_addr_b     in   ADDR_WIDTH  second swap address
//  host_we        in   1           host write request
//  host_addr_w    in   ADDR_WIDTH  host write address
//  host_data_w    in   DATA_WIDTH  host write data
//  host_wr_ready  out  1           host write accepted this cycle
//  mem_we         out  1           to swapper we
//  mem_address_w  out  ADDR_WIDTH  to swapper address_w
//  mem_data_w     out  DATA_WIDTH  to swapper data_w
//  mem_address_A  out  ADDR_WIDTH  to swapper address_A (registered)
//  mem_address_B  out  ADDR_WIDTH  to swapper address_B (registered)
//  mem_swap       out  1           to swapper swap (registered)
//  swap_done      out  1           one-cycle pulse per completed request
//  pending        out  clog2(FIFO_DEPTH)+1  queued requests not yet started
// BEHAVIOUR
//  - One clock, clk; reset synchronous active-high. Reset: FIFO empty, state IDLE, mem_swap=0,
//    mem_address_A/B=0, swap_done=0, pending=0. Reset mid-swap drops mem_swap next edge; queue lost.
//  - Push when req_valid&&req_ready; req_ready=0 when full (no push-while-full even with a pop).
//  - FSM states IDLE, SWAP, GAP:
//    IDLE: if FIFO non-empty -> pop head, latch A/B into mem_address_A/B, mem_swap<=1, cnt<=0, ->SWAP.
//    SWAP: mem_swap=1; cnt increments; when cnt==SWAP_CYCLES-1 -> mem_swap<=0, swap_done<=1, ->GAP.
//    GAP:  one cycle, mem_swap=0 (guarantees a low edge between requests); ->IDLE.
//  - Latency: request accepted at edge N into empty queue in IDLE -> mem_swap high from edge N+2,
//    high exactly SWAP_CYCLES cycles; swap_done high the cycle after mem_swap falls.
//  - Back-to-back requests: each costs SWAP_CYCLES+2 cycles (IDLE, SWAP*n, GAP).
//  - mem_address_A/B hold last value outside SWAP (do not return to 0).
//  - Write port (combinational pass-through): host_wr_ready = (state==IDLE) && !(FIFO non-empty);
//    mem_we = host_we && host_wr_ready; mem_address_w/mem_data_w = host inputs directly.
//    Swap start has priority over a simultaneous host write in IDLE; host must hold host_we.
//  - pending = FIFO occupancy; simultaneous push and pop leave it unchanged.
//  - No check that addresses are in range; full ADDR_WIDTH passed through unmodified.
// CONFIGURATION
//  SWAP_SKIP_SAME_EN defined: in IDLE, a head request with A==B is popped and retired without
//    entering SWAP: mem_swap stays 0, mem_address_A/B unchanged, swap_done pulses next cycle,
//    FSM goes IDLE->GAP->IDLE (2 cycles).
//  Not defined: A==B requests are issued like any other (full SWAP_CYCLES window).
// STRUCTURE
//  - Package swap_sched_pkg: state enum {IDLE,SWAP,GAP}; typedef struct {addr_a, addr_b} swap_req_t
//    parameterised by ADDR_WIDTH; localparam CNT_W = clog2(SWAP_CYCLES)+1.
//  - Sub-module swap_req_fifo: synchronous FIFO of swap_req_t, FIFO_DEPTH entries, push/pop,
//    full/empty/count, wrap-around via pointer MSB; sync active-high reset.
//  - Top: FSM, swap counter, output registers, write-port gating.
// TESTING
//  1 Reset: hold reset 2 cycles mid-operation -> all outputs 0, req_ready=1, pending=0.
//  2 Host writes 20..30 to addr 20..30, queue empty -> mem_we=1 each cycle, host_wr_ready=1.
//  3 Single request A=22,B=28 -> mem_swap high 3 cycles starting 2 edges after accept,
//    mem_address_A=22/B=28, one swap_done pulse, host_wr_ready=0 throughout.
//  4 Push 5 requests back-to-back, FIFO_DEPTH=4 -> req_ready=0 after 4th (or 5th if one popped),
//    all 5 retire in order, 5 swap_done pulses 5 cycles apart, mem_swap low 2 cycles between.
//  5 host_we held during swap of (3,9) -> mem_we=0 until GAP->IDLE with empty queue, then write lands.
//  6 Request A=B=10: without SWAP_SKIP_SAME_EN mem_swap 3 cycles; with it mem_swap never high,
//    swap_done pulses 2 cycles after accept.

Source files
------------

// File: rtl/swap_sched_pkg.sv
// -----------------------------------------------------------------------------
// swap_sched_pkg
// Shared definitions for the swap command scheduler:
//   - FSM state encodings (IDLE, SWAP, GAP) as plain logic constants
//   - sched_cnt_w(): width of the swap-window counter for a given SWAP_CYCLES
// The request record itself (addr_a/addr_b pair) depends on the instance's
// ADDR_WIDTH, so it is declared inside swap_cmd_scheduler where that
// parameter is known.
// Optional feature macro used by the scheduler: SWAP_SKIP_SAME_EN.
// -----------------------------------------------------------------------------
package swap_sched_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE = 2'd0;
    localparam sched_state_t ST_SWAP = 2'd1;
    localparam sched_state_t ST_GAP  = 2'd2;

    // Counter must hold values 0..SWAP_CYCLES-1; the +1 keeps it at least
    // one bit wide when SWAP_CYCLES == 1.
    function automatic int sched_cnt_w(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage : swap_sched_pkg

// File: rtl/swap_req_fifo.sv
// -----------------------------------------------------------------------------
// swap_req_fifo
// Synchronous FIFO for swap requests. Storage is an array written on push;
// the head entry is read through a register, so head_o/head_valid_o lag the
// pointer state by one clock. head_valid_o only asserts once head_o holds
// the entry at the read pointer and no pop has been issued since.
// Ports:
//   clk          clock
//   reset_i      synchronous active-high reset (pointers, head_valid)
//   push_i       write wr_data_i (ignored while full)
//   wr_data_i    entry to store
//   pop_i        retire head entry (ignored while empty)
//   head_o       registered head entry
//   head_valid_o head_o is valid and may be popped
//   full_o       no free entry
//   empty_o      no stored entry
//   count_o      current occupancy
// -----------------------------------------------------------------------------
module swap_req_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       head_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q;
    logic             head_valid_q, head_valid_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra MSB: equal low bits with differing MSB = full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // After a pop the read pointer moves, so the registered head is stale for
    // one cycle; hold valid low until it has been refreshed.
    assign head_valid_d = !empty_o && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
        head_q <= mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;

endmodule : swap_req_fifo

// File: rtl/swap_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// swap_cmd_scheduler
// Queues swap requests (address pairs) and sequences them onto the swapper's
// address_A/address_B/swap inputs; arbitrates the swapper's single write port
// so host writes are stalled while any swap is queued or in flight.
// Sequence per request: IDLE (pop) -> SWAP x SWAP_CYCLES -> GAP -> IDLE.
// A request accepted at edge N into an empty, idle scheduler raises mem_swap
// at edge N+2 (one cycle for the registered FIFO head, one for the pop).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready                request handshake (ready = queue not full)
//   req_addr_a/req_addr_b              request address pair
//   host_we/host_addr_w/host_data_w    host write request
//   host_wr_ready                      host write accepted this cycle
//   mem_we/mem_address_w/mem_data_w    write port to swapper (pass-through)
//   mem_address_A/mem_address_B        registered swap addresses (hold value)
//   mem_swap                           registered swap strobe
//   swap_done                          one-cycle pulse per retired request
//   pending                            queued requests not yet started
// Optional feature: define SWAP_SKIP_SAME_EN to retire A==B requests without
// a swap window (IDLE -> GAP -> IDLE, swap_done pulses, mem_swap stays low).
// -----------------------------------------------------------------------------
module swap_cmd_scheduler
    import swap_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr_a,
    input  logic [ADDR_WIDTH-1:0]         req_addr_b,
    input  logic                          host_we,
    input  logic [ADDR_WIDTH-1:0]         host_addr_w,
    input  logic [DATA_WIDTH-1:0]         host_data_w,
    output logic                          host_wr_ready,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_address_w,
    output logic [DATA_WIDTH-1:0]         mem_data_w,
    output logic [ADDR_WIDTH-1:0]         mem_address_A,
    output logic [ADDR_WIDTH-1:0]         mem_address_B,
    output logic                          mem_swap,
    output logic                          swap_done,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);
    localparam int CNT_W = sched_cnt_w(SWAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWAP_CYCLES - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
    } swap_req_t;

    // ---------------------------------------------------------------- queue
    swap_req_t  push_req;
    swap_req_t  head_req;
    logic       head_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign push_req.addr_a = req_addr_a;
    assign push_req.addr_b = req_addr_b;
    assign req_ready       = !fifo_full;

    swap_req_fifo #(
        .WIDTH (2 * ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_i      (reset),
        .push_i       (req_valid),
        .wr_data_i    (push_req),
        .pop_i        (pop),
        .head_o       (head_req),
        .head_valid_o (head_valid),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (pending)
    );

    // ------------------------------------------------------------------ FSM
    sched_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  swap_q, swap_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic                  skip_head;

`ifdef SWAP_SKIP_SAME_EN
    assign skip_head = (head_req.addr_a == head_req.addr_b);
`else
    assign skip_head = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        swap_d   = swap_q;
        done_d   = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (skip_head) begin
                        // Same-address swap is a no-op: retire it directly,
                        // still passing through GAP to keep request spacing.
                        done_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        addr_a_d = head_req.addr_a;
                        addr_b_d = head_req.addr_b;
                        swap_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_SWAP;
                    end
                end
            end
            ST_SWAP: begin
                if (cnt_q == CNT_LAST) begin
                    swap_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                // Guarantees mem_swap is sampled low between two requests.
                state_d = ST_IDLE;
            end
            default: begin
                swap_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            swap_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            swap_q   <= swap_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
        end
    end

    assign mem_swap      = swap_q;
    assign swap_done     = done_q;
    assign mem_address_A = addr_a_q;
    assign mem_address_B = addr_b_q;

    // ----------------------------------------------------------- write port
    // A queued request always wins over a host write: the write is only
    // accepted when the scheduler is idle with nothing waiting.
    assign host_wr_ready = (state_q == ST_IDLE) && fifo_empty;
    assign mem_we        = host_we && host_wr_ready;
    assign mem_address_w = host_addr_w;
    assign mem_data_w    = host_data_w;

endmodule : swap_cmd_scheduler

// File: tb/tb_swap_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_swap_cmd_scheduler
// Reference model: each accepted request gets a start edge computed with
// arithmetic (earliest 2 edges after acceptance, otherwise when the previous
// request's slot ends). All expected outputs are derived per cycle from the
// list of (accept, start, addresses, skip) records.
// -----------------------------------------------------------------------------
module tb_swap_cmd_scheduler;
    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SC    = 3;
    localparam int MAXR  = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr_a, req_addr_b;
    logic          host_we;
    logic [AW-1:0] host_addr_w;
    logic [DW-1:0] host_data_w;
    logic          host_wr_ready;
    logic          mem_we;
    logic [AW-1:0] mem_address_w;
    logic [DW-1:0] mem_data_w;
    logic [AW-1:0] mem_address_A, mem_address_B;
    logic          mem_swap;
    logic          swap_done;
    logic [2:0]    pending;

    always #5 clk = ~clk;

    swap_cmd_scheduler #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SWAP_CYCLES(SC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr_a    (req_addr_a),
        .req_addr_b    (req_addr_b),
        .host_we       (host_we),
        .host_addr_w   (host_addr_w),
        .host_data_w   (host_data_w),
        .host_wr_ready (host_wr_ready),
        .mem_we        (mem_we),
        .mem_address_w (mem_address_w),
        .mem_data_w    (mem_data_w),
        .mem_address_A (mem_address_A),
        .mem_address_B (mem_address_B),
        .mem_swap      (mem_swap),
        .swap_done     (swap_done),
        .pending       (pending)
    );

    // ------------------------------------------------------ reference model
    int            cyc = 0;
    int            n_req = 0;
    int            next_free = 0;
    int            r_start [MAXR];
    logic [AW-1:0] r_a [MAXR];
    logic [AW-1:0] r_b [MAXR];
    bit            r_skip [MAXR];
    bit            last_acc;
    int            n_checks = 0;
    int            n_fails = 0;

    function automatic int model_pending();
        int started = 0;
        for (int i = 0; i < n_req; i++) begin
            if (r_start[i] <= cyc) started++;
        end
        return n_req - started;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        int            pend;
        bit            busy, e_swap, e_done, e_hwr;
        logic [AW-1:0] e_a, e_b;
        pend   = model_pending();
        busy   = 1'b0;
        e_swap = 1'b0;
        e_done = 1'b0;
        e_a    = '0;
        e_b    = '0;
        for (int i = 0; i < n_req; i++) begin
            int s;
            s = r_start[i];
            if (r_skip[i]) begin
                if (cyc == s) begin busy = 1'b1; e_done = 1'b1; end
            end else begin
                if (cyc >= s && cyc < s + SC + 1) busy = 1'b1;
                if (cyc >= s && cyc < s + SC) e_swap = 1'b1;
                if (cyc == s + SC) e_done = 1'b1;
                if (s <= cyc) begin e_a = r_a[i]; e_b = r_b[i]; end
            end
        end
        e_hwr = !busy && (pend == 0);
        chk("req_ready",     32'(req_ready),     32'(pend < DEPTH));
        chk("pending",       32'(pending),       32'(pend));
        chk("host_wr_ready", 32'(host_wr_ready), 32'(e_hwr));
        chk("mem_we",        32'(mem_we),        32'(host_we && e_hwr));
        chk("mem_address_w", 32'(mem_address_w), 32'(host_addr_w));
        chk("mem_data_w",    32'(mem_data_w),    32'(host_data_w));
        chk("mem_swap",      32'(mem_swap),      32'(e_swap));
        chk("swap_done",     32'(swap_done),     32'(e_done));
        chk("mem_address_A", 32'(mem_address_A), 32'(e_a));
        chk("mem_address_B", 32'(mem_address_B), 32'(e_b));
    endtask

    // One clock: decide acceptance from current inputs, clock, update model,
    // then check all outputs 1 time unit after the edge.
    task automatic step();
        bit acc;
        bit sk;
        int st;
        acc = !reset && req_valid && (model_pending() < DEPTH);
        @(posedge clk);
        cyc++;
        last_acc = 1'b0;
        if (reset) begin
            n_req     = 0;
            next_free = 0;
        end else if (acc && n_req < MAXR) begin
`ifdef SWAP_SKIP_SAME_EN
            sk = (req_addr_a == req_addr_b);
`else
            sk = 1'b0;
`endif
            st = (cyc + 2 > next_free) ? cyc + 2 : next_free;
            r_start[n_req] = st;
            r_a[n_req]     = req_addr_a;
            r_b[n_req]     = req_addr_b;
            r_skip[n_req]  = sk;
            next_free      = st + (sk ? 2 : SC + 2);
            n_req++;
            last_acc = 1'b1;
        end
        #1;
        check_all();
        $display("cyc %0d rv=%0b acc=%0b A=%0d B=%0d swap=%0b done=%0b pend=%0d hwr=%0b we=%0b",
                 cyc, req_valid, last_acc, mem_address_A, mem_address_B, mem_swap,
                 swap_done, pending, host_wr_ready, mem_we);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int got;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr_a  = '0;
        req_addr_b  = '0;
        host_we     = 1'b0;
        host_addr_w = '0;
        host_data_w = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // Host writes with empty queue
        for (int k = 20; k <= 30; k++) begin
            host_we     = 1'b1;
            host_addr_w = AW'(k);
            host_data_w = DW'(k);
            step();
        end
        host_we = 1'b0;

        // Single request 22/28
        req_valid  = 1'b1;
        req_addr_a = 7'd22;
        req_addr_b = 7'd28;
        step();
        req_valid = 1'b0;
        repeat (8) step();

        // Five requests back to back into a 4-deep queue
        got = 0;
        for (int t = 0; t < 40 && got < 5; t++) begin
            req_valid  = 1'b1;
            req_addr_a = AW'(40 + got);
            req_addr_b = AW'(60 + got);
            step();
            if (last_acc) got++;
        end
        chk("five_accepted", 32'(got), 32'd5);
        req_valid = 1'b0;
        repeat (30) step();

        // Reset mid-operation
        req_valid  = 1'b1;
        req_addr_a = 7'd1;
        req_addr_b = 7'd2;
        repeat (4) step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();

        // Host write held during swap of (3,9)
        req_valid  = 1'b1;
        req_addr_a = 7'd3;
        req_addr_b = 7'd9;
        step();
        req_valid   = 1'b0;
        host_we     = 1'b1;
        host_addr_w = 7'd40;
        host_data_w = 8'h55;
        repeat (10) step();
        host_we = 1'b0;

        // Same-address request
        req_valid  = 1'b1;
        req_addr_a = 7'd10;
        req_addr_b = 7'd10;
        step();
        req_valid = 1'b0;
        repeat (8) step();

        // Randomised traffic, with one reset in the middle
        for (int t = 0; t < 400; t++) begin
            req_valid   = ($urandom_range(0, 9) < 4);
            req_addr_a  = AW'($urandom_range(0, 15));
            req_addr_b  = ($urandom_range(0, 3) == 0) ? req_addr_a : AW'($urandom_range(0, 127));
            host_we     = $urandom_range(0, 1) == 1;
            host_addr_w = AW'($urandom);
            host_data_w = DW'($urandom);
            reset       = (t == 200 || t == 201);
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        host_we   = 1'b0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_swap_cmd_scheduler
